// File: rtl/cpu.sv
// cpu: single-cycle 32-bit MIPS-subset core with built-in Fibonacci ROM, register file and data memory.
// Optional CPU_TRACE_EN adds a simulation-only trace of every register-file write.
module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [0:31];

    // $0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (we && wa != 5'd0)
            regs[wa] <= wd;

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
endmodule

module cpu (
    input logic clk,
    input logic reset
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [31:0] pc, pc_plus4, pc_next, instr;
    logic [31:0] imm_ext, br_target, j_target;
    logic [31:0] rd1, rd2, alu_b, alu_y, mem_rdata, wb_data;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, rf_wa;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
    logic        funct_ok, rf_we, take_br;
    logic [31:0] dmem [0:63];

    always_comb begin
        case (pc[7:2])
            6'd0:    instr = 32'h2002_0000;
            6'd1:    instr = 32'h2003_0001;
            6'd2:    instr = 32'h2005_0005;
            6'd3:    instr = 32'h0043_1020;
            6'd4:    instr = 32'h0043_1820;
            6'd5:    instr = 32'h20a5_ffff;
            6'd6:    instr = 32'h14a0_fffc;
            6'd7:    instr = 32'h0040_2020;
            6'd8:    instr = 32'h1000_ffff;
            default: instr = 32'h0000_0000;
        endcase
    end

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    // R-type with a nonzero shamt field is not a legal add/sub/and/or/slt and falls through as a NOP
    assign funct_ok = funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                      funct == 6'h25 || funct == 6'h2a;
    assign is_r    = op == OP_RTYPE && instr[10:6] == 5'd0 && funct_ok;
    assign is_addi = op == OP_ADDI;
    assign is_lw   = op == OP_LW;
    assign is_sw   = op == OP_SW;
    assign is_beq  = op == OP_BEQ;
    assign is_bne  = op == OP_BNE;
    assign is_j    = op == OP_J;

    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    cpu_regfile reg_file (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (rf_wa),
        .wd    (wb_data),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign alu_b = is_r ? rd2 : imm_ext;

    always_comb begin
        alu_y = rd1 + alu_b;
        if (is_r)
            alu_y = funct == 6'h22 ? rd1 - rd2 :
                    funct == 6'h24 ? rd1 & rd2 :
                    funct == 6'h25 ? rd1 | rd2 :
                    funct == 6'h2a ? {31'd0, $signed(rd1) < $signed(rd2)} :
                    rd1 + rd2;
    end

    assign mem_rdata = dmem[alu_y[7:2]];

    always_ff @(posedge clk)
        if (is_sw) dmem[alu_y[7:2]] <= rd2;

    assign rf_we   = is_r || is_addi || is_lw;
    assign rf_wa   = is_r ? rd : rt;
    assign wb_data = is_lw ? mem_rdata : alu_y;

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign take_br   = (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);
    assign pc_next   = is_j ? j_target : take_br ? br_target : pc_plus4;

    always_ff @(posedge clk or negedge reset)
        if (!reset) pc <= '0;
        else        pc <= pc_next;

`ifdef CPU_TRACE_EN
    int unsigned trace_cycle;

    always_ff @(posedge clk or negedge reset)
        if (!reset) trace_cycle <= 0;
        else        trace_cycle <= trace_cycle + 1;

    always_ff @(posedge clk)
        if (reset && rf_we && rf_wa != 5'd0)
            $display("[cpu] cycle=%0d pc=%08h $%0d <= %08h", trace_cycle, pc, rf_wa, wb_data);
`endif
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: checks the Fibonacci program's register/PC trajectory, halt, and async reset behaviour.
module tb_cpu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct {
        logic [31:0] pc, r2, r3, r4, r5;
    } st_t;

    typedef struct {
        int   edges;
        st_t  exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fib(input int k);
        logic [31:0] a = 0, b = 1, t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Architectural state after n edges, from the program's loop structure rather than its encoding
    function automatic st_t model(input int n);
        st_t s = '{pc: 32'd4 * n, r2: 0, r3: 0, r4: 0, r5: 0};
        int i, p;
        if (n >= 2) s.r3 = 1;
        if (n >= 3) s.r5 = 5;
        if (n >= 4 && n <= 23) begin
            i = (n - 4) / 4;
            p = (n - 4) % 4;
            s.r2 = fib(2 * i + 2);
            s.r3 = p >= 1 ? fib(2 * i + 3) : fib(2 * i + 1);
            s.r5 = p >= 2 ? 4 - i : 5 - i;
            s.pc = p == 0 ? 32'h10 : p == 1 ? 32'h14 : p == 2 ? 32'h18 : (i < 4 ? 32'h0c : 32'h1c);
        end
        if (n >= 24) s = '{pc: 32'h20, r2: 55, r3: 89, r4: 55, r5: 0};
        return s;
    endfunction

    task automatic check_st(input string tag, input st_t e);
        chk($sformatf("%s pc", tag), dut.pc, e.pc);
        for (int r = 0; r < 32; r++)
            chk($sformatf("%s r%0d", tag, r), dut.reg_file.regs[r],
                r == 2 ? e.r2 : r == 3 ? e.r3 : r == 4 ? e.r4 : r == 5 ? e.r5 : 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        n = 0;
    endtask

    task automatic run_edges(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            n++;
            check_st($sformatf("%s e%0d", tag, n), model(n));
        end
    endtask

    task automatic async_reset_now(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_st($sformatf("%s async", tag), model(0));
    endtask

    always @(negedge clk) chk("r0 hardwired", dut.reg_file.regs[0], 32'd0);

    vec_t vecs[$];

    initial begin
        vecs.push_back('{0,  '{32'h00, 0, 0, 0, 0}});
        vecs.push_back('{1,  '{32'h04, 0, 0, 0, 0}});
        vecs.push_back('{2,  '{32'h08, 0, 1, 0, 0}});
        vecs.push_back('{3,  '{32'h0c, 0, 1, 0, 5}});
        vecs.push_back('{4,  '{32'h10, 1, 1, 0, 5}});
        vecs.push_back('{5,  '{32'h14, 1, 2, 0, 5}});
        vecs.push_back('{6,  '{32'h18, 1, 2, 0, 4}});
        vecs.push_back('{7,  '{32'h0c, 1, 2, 0, 4}});
        vecs.push_back('{11, '{32'h0c, 3, 5, 0, 3}});
        vecs.push_back('{22, '{32'h18, 55, 89, 0, 0}});
        vecs.push_back('{23, '{32'h1c, 55, 89, 0, 0}});
        vecs.push_back('{24, '{32'h20, 55, 89, 55, 0}});
        vecs.push_back('{25, '{32'h20, 55, 89, 55, 0}});
        vecs.push_back('{50, '{32'h20, 55, 89, 55, 0}});

        #20;
        check_st("initial reset", model(0));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_st($sformatf("held reset c%0d", i), model(0));
        end

        foreach (vecs[v]) begin
            release_reset();
            repeat (vecs[v].edges) @(posedge clk);
            #1;
            check_st($sformatf("vec n=%0d", vecs[v].edges), vecs[v].exp);
            async_reset_now($sformatf("vec n=%0d", vecs[v].edges));
        end

        release_reset();
        run_edges("run+halt", 130);

        async_reset_now("post-halt");
        release_reset();
        run_edges("pre-abort", 10);
        reset = 1'b0;
        #1;
        check_st("mid-run abort", model(0));
        release_reset();
        run_edges("rerun", 30);

        for (int t = 0; t < 20; t++) begin
            async_reset_now($sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_st($sformatf("rnd%0d hold", t), model(0));
            end
            release_reset();
            run_edges($sformatf("rnd%0d", t), $urandom_range(1, 40));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle 32-bit MIPS-subset processor with a built-in instruction ROM, 32×32 register file and word data memory. It is the top level of the processor design. After reset it runs a fixed Fibonacci program that leaves Fibonacci(10) = 55 in register $4, then halts in a self-loop. It has no data outputs; benches observe state hierarchically.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears state immediately; release is sampled on the next rising edge of clk.
- Required hierarchy: register-file instance `reg_file`, containing array `regs[0:31]` of 32-bit words.

## Operation
- Executes one instruction per clock: fetch, decode, execute, memory access and writeback all in the same cycle.
- PC is byte-addressed, 32 bits, and advances by 4. The ROM has 64 words, indexed by PC[7:2], so PC wraps within the ROM.
- Data memory has 64 words, indexed by address[7:2]. It has a combinational read and a synchronous write, and is not cleared by reset.
- Supported instructions:
  - R-type add, sub, and, or, slt (opcode 0x00; funct 0x20, 0x22, 0x24, 0x25, 0x2A).
  - addi (0x08), lw (0x23), sw (0x2B), beq (0x04), bne (0x05), j (0x02).
- Any other encoding, including all-zero words, executes as a NOP with no state change other than PC+4.
- Immediates are sign-extended. Arithmetic is 32-bit two's complement, wraps on overflow and raises no exception. slt is a signed compare.
- Branch target is PC+4+(sext(imm)<<2). Jump target is {PC+4[31:28], target, 2'b00}.
- $0 always reads as 0; writes to $0 are discarded.
- The register file has two combinational read ports and one synchronous write port. A read of the register being written in the same cycle returns the old value.
- ROM contents (byte address: instruction):
  - 0x00 addi $2,$0,0
  - 0x04 addi $3,$0,1
  - 0x08 addi $5,$0,5
  - 0x0C add $2,$2,$3
  - 0x10 add $3,$2,$3
  - 0x14 addi $5,$5,-1
  - 0x18 bne $5,$0,-4
  - 0x1C add $4,$2,$0
  - 0x20 beq $0,$0,-1 (halt)
  - All remaining words are 0.

## Timing
- While reset=0: PC=0 and all regs=0, regardless of clk.
- The first rising edge after release executes the instruction at address 0x00.
- The loop runs 5 times. Values after each pass ($2/$3): 1/2, 3/5, 8/13, 21/34, 55/89.
- $4 becomes 55 on the 24th rising edge after reset release. Final state: $2=55, $3=89, $5=0.
- From edge 25 onward the PC stays at 0x20 indefinitely and no register changes.
- Asserting reset mid-run aborts execution immediately. After release the program re-runs from scratch with identical timing.

## Configuration
- CPU_TRACE_EN defined: simulation-only $display on every register-file write, showing cycle count, PC, destination register and value. This adds no functional state and changes no behaviour.
- CPU_TRACE_EN undefined: no trace logic or output; the design is fully synthesizable.

## Test plan
- **Program result:** hold reset=0 for 20 ns, release, run 50 cycles → regs[4]=55, regs[2]=55, regs[3]=89, regs[5]=0.
- **Exact latency:** count edges after release → regs[4]=0 through edge 23 and 55 at edge 24.
- **Halt:** after edge 30, PC=0x20 on every subsequent edge and all regs remain unchanged for 100 cycles.
- **Mid-run reset:** assert reset at edge 10 → PC=0 and all regs=0 immediately, without waiting for a clock. Release → regs[4]=55 again exactly 24 edges later.
- **Held reset:** keep reset=0 for 50 clock cycles → PC stays 0 and all regs stay 0.
- **$0 hardwired:** inspect regs[0] throughout the whole run → it reads 0 at all times.
